// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch (IF) and load/store (MEM).
// Define MEM_ARB_ROUND_ROBIN_EN to make ties alternate; otherwise MEM always wins a tie.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        stall_req,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("mem_port_arbiter: WAIT_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_mem_q, gnt_mem_d;
    logic        gnt_we_q, gnt_we_d;
    logic        ram_ce_q, ram_ce_d;
    logic        ram_we_q, ram_we_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        grant_mem;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_if_q, last_if_d;

    // On a tie, serve whichever side did not get the previous grant.
    always_comb begin
        grant_mem = mem_req & (~if_req | last_if_q);
    end
`else
    always_comb begin
        grant_mem = mem_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_mem_d   = gnt_mem_q;
        gnt_we_d    = gnt_we_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_sel_d   = ram_sel_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_if_d   = last_if_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_req || if_req) begin
                    state_d   = S_ISSUE;
                    ram_ce_d  = 1'b1;
                    gnt_mem_d = grant_mem;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_if_d = ~grant_mem;
`endif
                    if (grant_mem) begin
                        gnt_we_d    = mem_we;
                        ram_we_d    = mem_we;
                        ram_sel_d   = mem_sel;
                        ram_addr_d  = mem_addr;
                        ram_wdata_d = mem_wdata;
                    end else begin
                        gnt_we_d    = 1'b0;
                        ram_sel_d   = 4'hF;
                        ram_addr_d  = if_addr;
                        ram_wdata_d = 32'h0;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (gnt_mem_q) begin
                        mem_ack_d = 1'b1;
                        if (!gnt_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            gnt_mem_q   <= 1'b0;
            gnt_we_q    <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= 4'h0;
            ram_addr_q  <= 32'h0;
            ram_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_if_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_mem_q   <= gnt_mem_d;
            gnt_we_q    <= gnt_we_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_if_q   <= last_if_d;
`endif
        end
    end

    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;
    assign ram_sel   = ram_sel_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;

    // Drops in the ack cycle so the pipeline advances on the following edge.
    assign stall_req = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous data/instruction RAM between the instruction-fetch requester (IF) and the load/store requester (MEM stage).
- Sequences each access through a fixed-latency FSM, returns registered read data and a one-cycle ack, and raises a stall request to pipeline control while any requester waits.
- Sits between the IF/MEM stages and the RAM macro. Allows a unified-memory build without changing the stage datapath.

Parameters:
- WAIT_CYCLES, 1, RAM read latency in cycles from the ram_ce cycle to valid ram_rdata; legal range 1..15.

Ports:
- clk input 1 rising-edge clock
- rst input 1 reset, synchronous, active-high
- if_req input 1 fetch request; held stable until if_ack
- if_addr input 32 fetch word address
- if_rdata output 32 fetched instruction, registered
- if_ack output 1 one-cycle fetch completion pulse
- mem_req input 1 load/store request; held stable until mem_ack
- mem_we input 1 1=store, 0=load
- mem_sel input 4 byte lane enables
- mem_addr input 32 load/store address
- mem_wdata input 32 store data
- mem_rdata output 32 load data, registered
- mem_ack output 1 one-cycle load/store completion pulse
- stall_req output 1 to pipeline control; high while any request is pending and not yet acked
- ram_ce output 1 RAM chip enable, one cycle per access
- ram_we output 1 RAM write enable
- ram_sel output 4 RAM byte enables
- ram_addr output 32 RAM address
- ram_wdata output 32 RAM write data
- ram_rdata input 32 RAM read data

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - ram_ce, ram_we, if_ack, mem_ack = 0.
  - ram_sel, ram_addr, ram_wdata, if_rdata, mem_rdata = 0.
  - Wait counter = 0; last-grant flag = IF.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - At an edge with mem_req or if_req high: grant by priority (MEM over IF; see Optional Feature) and go to ISSUE.
  - Latch grant ID; drive the RAM outputs from the granted requester.
  - IF grant drives ram_we=0, ram_sel=4'b1111, ram_wdata=0.
- ISSUE:
  - ram_ce=1 for exactly this cycle; load counter=WAIT_CYCLES-1 and go to WAIT.
  - ram_ce, ram_we return to 0 on leaving ISSUE. ram_addr, ram_sel, ram_wdata hold until the next grant.
- WAIT:
  - Decrement counter each edge.
  - At the edge where counter==0:
    - Load grant: capture ram_rdata into mem_rdata.
    - IF grant: capture ram_rdata into if_rdata.
    - Store grant: mem_rdata unchanged.
  - Then assert the granted ack and go to DONE.
- DONE:
  - Granted ack high for this one cycle only; requests are ignored.
  - Next edge goes to IDLE with ack=0.
- Latency: request sampled at edge E0 gives ack high during the cycle after edge E0+WAIT_CYCLES+1. One access per WAIT_CYCLES+3 cycles.
- stall_req is combinational: (if_req & ~if_ack) | (mem_req & ~mem_ack). Low in the ack cycle so the pipeline advances on that edge.
- Simultaneous requests in IDLE: only one is granted. The loser stays pending, keeps stall_req high, and is granted in the next IDLE.
- A request that drops before being granted is dropped silently. A request that drops after grant still completes and acks; requesters must not do this.
- No alignment checking; mem_sel is passed through unmodified.
- Reset mid-access: abandoned at the reset edge. A store whose ram_ce cycle already occurred stays committed in RAM. No ack is issued.
- WAIT_CYCLES outside 1..15 is an elaboration error.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are high in IDLE, grant the requester not granted last; the last-grant flag updates on each grant.
  - A single request is granted regardless of the flag.
  - Prevents fetch starvation under back-to-back loads/stores.
- Undefined:
  - Fixed priority, MEM always wins on a tie; no last-grant flag is implemented.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=1 and mem_req=1 → ram_ce, if_ack, mem_ack, stall_req-independent outputs all 0; no grant until the first edge after rst falls.
- Fetch, WAIT_CYCLES=1: if_req=1, if_addr=0x0000_0040, ram_rdata=0x2401_0005 during the cycle after ram_ce:
  - ram_ce high 1 cycle with ram_addr=0x40, ram_sel=4'hF, ram_we=0.
  - if_ack high 1 cycle, 3 cycles after the request edge, with if_rdata=0x2401_0005.
- Store, WAIT_CYCLES=3: mem_req=1, mem_we=1, mem_sel=4'b0011, mem_addr=0x100, mem_wdata=0xDEAD_BEEF:
  - ram_we=1, ram_sel=4'b0011, ram_wdata=0xDEADBEEF during ram_ce.
  - mem_ack 5 edges after the request; mem_rdata unchanged.
- Tie, feature undefined: if_req and mem_req both high, MEM is a load of 0x200:
  - MEM granted first; IF acked 4 cycles later.
  - stall_req stays 1 until the IF ack cycle.
- Tie, MEM_ARB_ROUND_ROBIN_EN defined: three consecutive ties → grant order MEM, IF, MEM (flag starts at IF after reset).
- Reset mid-access: assert rst during WAIT of a load → no mem_ack; state returns to IDLE; the next request completes with normal latency.
